sub_bytes_serial: RTL

- Forward AES SubBytes engine for the encryption datapath; it is the counterpart of the decryption-side inverse substitution.
- Accepts one 128-bit state over a valid/ready handshake and substitutes all 16 bytes through LANES shared forward S-box instances over 16/LANES beats.
- Returns the substituted state over a valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the iterative encryption round controller.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/sbox_fwd.sv | 35 +++
 rtl/sub_bytes_serial.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the encryption-side datapath blocks.
//   AES_STATE_W / AES_BYTE_W : state and byte widths
//   sb_state_t               : SubBytes engine FSM encoding
//   byte_msb(k)              : MSB bit position of state byte k (column-major)
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_BUSY,
    SB_DONE
  } sb_state_t;

  // Byte k of the state lives at [127-8k -: 8].
  function automatic int unsigned byte_msb(input int unsigned k);
    return AES_STATE_W - 1 - AES_BYTE_W * k;
  endfunction

endpackage

// File: rtl/sbox_fwd.sv
// Forward AES S-box (FIPS-197), purely combinational, defined for all 256 inputs.
//   in_byte  : byte to substitute
//   out_byte : S(in_byte)
module sbox_fwd
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  // Entry 0 sits in the top byte, so entry x starts at bit (255-x)*8.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    out_byte = SBOX_TBL[{~in_byte, 3'b000} +: AES_BYTE_W];
  end

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial forward SubBytes engine: accepts one 128-bit state, substitutes
// LANES bytes per beat through shared S-boxes over 16/LANES beats, and
// returns the result over a valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, state_in (byte k = [127-8k -: 8])
//   out_valid/out_ready : output handshake, state_out (same byte order)
//   busy                : FSM not in IDLE
// Optional build macro SUBBYTES_PIPE_EN: registers the S-box outputs so the
// writeback lands one cycle after lookup (BUSY lasts N+1 cycles).
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  localparam int unsigned NBEATS = 16 / LANES;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_t              state_q, state_d;
  logic [AES_STATE_W-1:0] work_q, work_d, work_wb;
  logic [AES_STATE_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [AES_BYTE_W-1:0]  lk_in   [LANES];
  logic [AES_BYTE_W-1:0]  lk_out  [LANES];
  logic [AES_BYTE_W-1:0]  wb_data [LANES];
  logic                   lk_en, wb_en, wb_last;
  logic [CNT_W-1:0]       wb_beat;

  // Lookup side: bytes of the current beat feed the shared S-boxes.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lk_in[i] = work_q[byte_msb(32'(cnt_q) * LANES + i) -: AES_BYTE_W];
    end
  end

  for (genvar i = 0; i < int'(LANES); i++) begin : g_sbox
    sbox_fwd u_sbox (
      .in_byte  (lk_in[i]),
      .out_byte (lk_out[i])
    );
  end

`ifdef SUBBYTES_PIPE_EN
  logic [AES_BYTE_W-1:0] pdat_q [LANES];
  logic [AES_BYTE_W-1:0] pdat_d [LANES];
  logic                  pvld_q, pvld_d;
  logic                  plast_q, plast_d;
  logic                  lkdone_q, lkdone_d;
  logic [CNT_W-1:0]      pbeat_q, pbeat_d;

  // Lookups stop after the last beat; the final BUSY cycle only drains
  // the pipeline register into the work register.
  always_comb begin
    lk_en   = (state_q == SB_BUSY) && !lkdone_q;
    pvld_d  = lk_en;
    plast_d = (cnt_q == LAST_BEAT);
    pbeat_d = cnt_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      pdat_d[i]  = lk_out[i];
      wb_data[i] = pdat_q[i];
    end
    lkdone_d = lkdone_q;
    if (state_q != SB_BUSY) begin
      lkdone_d = 1'b0;
    end else if (lk_en && (cnt_q == LAST_BEAT)) begin
      lkdone_d = 1'b1;
    end
    wb_en   = (state_q == SB_BUSY) && pvld_q;
    wb_last = plast_q;
    wb_beat = pbeat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pvld_q   <= 1'b0;
      plast_q  <= 1'b0;
      lkdone_q <= 1'b0;
      pbeat_q  <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        pdat_q[i] <= '0;
      end
    end else begin
      pvld_q   <= pvld_d;
      plast_q  <= plast_d;
      lkdone_q <= lkdone_d;
      pbeat_q  <= pbeat_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        pdat_q[i] <= pdat_d[i];
      end
    end
  end
`else
  always_comb begin
    lk_en   = (state_q == SB_BUSY);
    wb_en   = lk_en;
    wb_last = (cnt_q == LAST_BEAT);
    wb_beat = cnt_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      wb_data[i] = lk_out[i];
    end
  end
`endif

  // Writeback side: substituted bytes return to their own positions.
  always_comb begin
    work_wb = work_q;
    if (wb_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        work_wb[byte_msb(32'(wb_beat) * LANES + i) -: AES_BYTE_W] = wb_data[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SB_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = SB_BUSY;
        end
      end
      SB_BUSY: begin
        work_d = work_wb;
        // Wrap on the last beat so the lookup index never leaves the state.
        if (lk_en) begin
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
        end
        if (wb_en && wb_last) begin
          out_d   = work_wb;
          state_d = SB_DONE;
        end
      end
      SB_DONE: begin
        if (out_ready) begin
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == SB_IDLE);
    out_valid = (state_q == SB_DONE);
    busy      = (state_q != SB_IDLE);
    state_out = out_q;
  end

endmodule
